// File: rtl/mem_ctrl_pkg.sv
// Shared types and default sizing for the memory access sequencer.
// Note: the timeout feature is enabled by defining MEM_TIMEOUT_EN.
package mem_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ACCESS   = 2'd1,
      COMPLETE = 2'd2
   } state_t;

   localparam int DEF_DATA_W  = 16;
   localparam int DEF_ADDR_W  = 16;
   localparam int DEF_TIMEOUT = 15;

endpackage

// File: rtl/mem_timeout_counter.sv
// Counts cycles spent waiting on memory.
// Flags the last permitted cycle; only instantiated when MEM_TIMEOUT_EN is defined.
module mem_timeout_counter #(
   parameter int TIMEOUT = 15
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   logic [CNT_W-1:0] count_reg;

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         count_reg <= '0;
      end else if (enable) begin
         count_reg <= count_reg + 1'b1;
      end
   end

   // High during the TIMEOUT-th enabled cycle, so expiry and a late ack are seen together.
   assign expired = enable && (count_reg == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_access_ctrl.sv
// Single-outstanding memory access sequencer feeding the MDR input stage.
// Optional wait-state timeout is built when MEM_TIMEOUT_EN is defined.
module mem_access_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int DATA_W  = DEF_DATA_W,
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              req_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_rd,
   output logic              mem_wr,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic [DATA_W-1:0] mdr_data,
   output logic              mdr_load,
   output logic              done,
   output logic              err
);

   state_t            state_reg, state_next;
   logic              op_reg;
   logic              load_ok_reg;
   logic [ADDR_W-1:0] addr_reg;
   logic [DATA_W-1:0] wdata_reg;
   logic [DATA_W-1:0] mdr_data_reg;
   logic              accept;
   logic              ack_hit;
   logic              timeout_hit;

   assign accept  = (state_reg == IDLE) && req_valid;
   assign ack_hit = (state_reg == ACCESS) && mem_ack;

`ifdef MEM_TIMEOUT_EN
   logic err_reg;

   mem_timeout_counter #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk     (clk),
      .rst     (rst),
      .clear   (state_reg != ACCESS),
      .enable  (state_reg == ACCESS),
      .expired (timeout_hit)
   );

   // Ack takes priority over a coincident expiry.
   always_ff @(posedge clk) begin
      if (rst) begin
         err_reg <= 1'b0;
      end else if (accept) begin
         err_reg <= 1'b0;
      end else if (timeout_hit && !mem_ack) begin
         err_reg <= 1'b1;
      end
   end

   assign err = err_reg;
`else
   assign timeout_hit = 1'b0;
   assign err         = 1'b0;
`endif

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:     if (req_valid) state_next = ACCESS;
         ACCESS:   if (mem_ack || timeout_hit) state_next = COMPLETE;
         COMPLETE: state_next = IDLE;
         default:  state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= IDLE;
         op_reg       <= 1'b0;
         load_ok_reg  <= 1'b0;
         addr_reg     <= '0;
         wdata_reg    <= '0;
         mdr_data_reg <= '0;
      end else begin
         state_reg <= state_next;
         if (accept) begin
            addr_reg  <= req_addr;
            wdata_reg <= req_wdata;
            op_reg    <= req_we;
         end
         // Last ACCESS cycle decides whether COMPLETE pulses the MDR load.
         if (state_reg == ACCESS) begin
            load_ok_reg <= mem_ack && !op_reg;
         end
         if (ack_hit && !op_reg) begin
            mdr_data_reg <= mem_rdata;
         end
      end
   end

   assign req_ready = (state_reg == IDLE);
   assign mem_addr  = addr_reg;
   assign mem_wdata = wdata_reg;
   assign mem_rd    = (state_reg == ACCESS) && !op_reg;
   assign mem_wr    = (state_reg == ACCESS) && op_reg;
   assign mdr_data  = mdr_data_reg;
   assign done      = (state_reg == COMPLETE);
   assign mdr_load  = (state_reg == COMPLETE) && load_ok_reg;

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Memory access sequencer sitting directly upstream of the memory data register input stage. It accepts one read or write request at a time from the control unit, drives the memory strobes with a ready/acknowledge handshake tolerant of wait states, and on reads delivers the returned word together with a one-cycle load strobe. That word and strobe feed the MDR's memory data input and its load enable.

## Interface
- DATA_W, 16: data width.
- ADDR_W, 16: address width.
- TIMEOUT, 15: max ACCESS cycles before abort; only used with MEM_TIMEOUT_EN.
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  control unit requests an access.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  access address.
- req_wdata  in  DATA_W  write data.
- req_ready  out  1  high only in IDLE.
- mem_addr  out  ADDR_W  registered address to memory.
- mem_wdata  out  DATA_W  registered write data.
- mem_rd  out  1  read strobe, held through access.
- mem_wr  out  1  write strobe, held through access.
- mem_rdata  in  DATA_W  read data, valid when mem_ack high.
- mem_ack  in  1  memory completion.
- mdr_data  out  DATA_W  captured read word, feeds MDR memory data input.
- mdr_load  out  1  one-cycle load strobe, feeds MDR load enable.
- done  out  1  one-cycle completion pulse.
- err  out  1  timeout flag.

## Operation
- States: IDLE, ACCESS, COMPLETE.
- IDLE: req_ready=1. On req_valid, latch req_addr, req_wdata and req_we into mem_addr, mem_wdata and the op register, then go to ACCESS.
- ACCESS: mem_rd=~op or mem_wr=op. Address and data stay stable. On mem_ack sampled high:
  - Read: capture mem_rdata into mdr_data.
  - Both: drop strobes and go to COMPLETE.
- COMPLETE: done=1. mdr_load=1 only for a successful read. Return to IDLE.
- Writes never change mdr_data and never pulse mdr_load.
- mem_ack is ignored outside ACCESS.
- req_valid is ignored outside IDLE; it is not queued.
- Reset values: state IDLE, mem_addr=0, mem_wdata=0, mdr_data=0, mem_rd=0, mem_wr=0, mdr_load=0, done=0, err=0. req_ready=1 from the first cycle after reset.
- rst mid-access: all strobes drop at that edge. The request is discarded with no done pulse.

## Timing
- Request accepted at edge T (req_valid & req_ready).
- ACCESS occupies cycles T+1 through T+1+W, where W is the number of wait cycles with mem_ack low.
- COMPLETE is the following cycle. With zero wait, done and mdr_load are high in cycle T+2, and req_ready returns in T+3.
- Throughput: one access per 3+W cycles.
- mdr_data is stable from the COMPLETE cycle until the next successful read completes.

## Configuration
- Macro: MEM_TIMEOUT_EN.
- Defined:
  - A counter counts ACCESS cycles. If it reaches TIMEOUT with mem_ack still low, strobes drop and the FSM enters COMPLETE with done=1, mdr_load=0 and err set.
  - err stays high until the next accepted request or rst.
  - If mem_ack and expiry occur in the same cycle, mem_ack wins and the access succeeds.
- Undefined: no counter. ACCESS waits indefinitely and err is tied to 0.

## Structure
- Package mem_ctrl_pkg holds:
  - the state enum (IDLE, ACCESS, COMPLETE);
  - default DATA_W, ADDR_W and TIMEOUT constants.
- One sub-module, mem_timeout_counter. It has clear and enable inputs and an expired output, and is instantiated only under MEM_TIMEOUT_EN.

## Test plan
- Zero-wait read: req addr 0x0040, mem_ack high on first ACCESS cycle with mem_rdata=0xBEEF. Required: done=1 and mdr_load=1 at T+2, mdr_data=0xBEEF, req_ready=1 at T+3.
- Wait-state write: req_we=1, addr 0x0100, data 0x1234, mem_ack after 3 cycles. Required:
  - mem_wr high for 4 cycles with mem_addr and mem_wdata stable;
  - done at T+5;
  - mdr_load never asserted; mdr_data unchanged.
- Busy rejection: second req_valid (addr 0x0002) held during an ACCESS. Required: req_ready=0 and mem_addr stays 0x0001 until the first access finishes. The second request is accepted only after the return to IDLE.
- Reset mid-access: rst asserted in the second ACCESS cycle of a read. Required: mem_rd=0, done=0 and mdr_load=0 at the next edge, all outputs at reset values, req_ready=1 after rst is released.
- Timeout (MEM_TIMEOUT_EN, TIMEOUT=15): read with mem_ack held low. Required:
  - mem_rd drops after 15 ACCESS cycles;
  - done=1 with err=1 and mdr_load=0;
  - err clears on the next accepted request.
- Ack/timeout coincidence (MEM_TIMEOUT_EN): mem_ack asserted in ACCESS cycle 15 with 0x5A5A. Required: mdr_load=1, mdr_data=0x5A5A, err=0.
